fib_lfsr_cfg_seq: RTL and testbench

AXI4-Lite master sequencer that configures the Fib_LFSR peripheral and harvests its output without software involvement. On a start pulse it writes the seed and control registers, then performs N single reads of the LFSR output register. Each read word is forwarded on a valid/ready stream. It sits between a local control FSM or DMA front-end and the Fib_LFSR S00_AXI slave port.

---
 rtl/fib_lfsr_cfg_seq.sv | 203 ++++++++++++++++++++
 tb/tb_fib_lfsr_cfg_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_lfsr_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module : fib_lfsr_cfg_seq
// AXI4-Lite master that programs the Fib_LFSR seed/control registers and then
// streams N reads of its output register out on a valid/ready port.
// Rev    : 1.0  initial release
// ============================================================================
module fib_lfsr_cfg_seq #(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = 32'h0000_0000,
  parameter int                            C_CNT_WIDTH        = 16
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic                              start,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     seed,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     ctrl_word,
  input  logic [C_CNT_WIDTH-1:0]            num_reads,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     out_tdata,
  output logic                              out_tvalid,
  input  logic                              out_tready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                        m_axi_awprot,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                        m_axi_arprot,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready
);

  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] c_ADDR_SEED = C_BASE_ADDR;
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] c_ADDR_CTRL = C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'(4);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] c_ADDR_OUT  = C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'(12);
  localparam logic [C_CNT_WIDTH-1:0]        c_CNT_ONE   = C_CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_SEED = 3'd1,
    S_WR_CTRL = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_DATA = 3'd4,
    S_PUSH    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t                          r_state;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_ctrl;
  logic [C_CNT_WIDTH-1:0]          r_cnt;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_awaddr;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_araddr;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_tdata;
  logic r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready, r_tvalid;
  logic r_busy, r_done, r_error;

  logic w_aw_fin;
  logic w_w_fin;
  logic w_b_hs;

  // A channel counts as finished once its valid has dropped or is handshaking now
  assign w_aw_fin = ~r_awvalid | m_axi_awready;
  assign w_w_fin  = ~r_wvalid  | m_axi_wready;
  assign w_b_hs   = r_bready & m_axi_bvalid;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state   <= S_IDLE;
      r_ctrl    <= '0;
      r_cnt     <= '0;
      r_awaddr  <= '0;
      r_araddr  <= '0;
      r_wdata   <= '0;
      r_tdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_tvalid  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_error   <= 1'b0;
            r_busy    <= 1'b1;
            r_ctrl    <= ctrl_word;
            r_cnt     <= num_reads;
            r_awaddr  <= c_ADDR_SEED;
            r_wdata   <= seed;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_state   <= S_WR_SEED;
          end
        end
        S_WR_SEED, S_WR_CTRL: begin
          if (m_axi_awready) r_awvalid <= 1'b0;
          if (m_axi_wready)  r_wvalid  <= 1'b0;
          if (w_b_hs) begin
            r_bready <= 1'b0;
            if (m_axi_bresp != 2'b00) begin
              r_error <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else if (r_state == S_WR_SEED) begin
              r_awaddr  <= c_ADDR_CTRL;
              r_wdata   <= r_ctrl;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR_CTRL;
            end else if (r_cnt == '0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_araddr  <= c_ADDR_OUT;
              r_arvalid <= 1'b1;
              r_state   <= S_RD_ADDR;
            end
          end else if (!r_bready) begin
            r_bready <= w_aw_fin & w_w_fin;
          end
        end
        S_RD_ADDR: begin
          if (m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (m_axi_rvalid) begin
            r_rready <= 1'b0;
            r_tdata  <= m_axi_rdata;
            if (m_axi_rresp != 2'b00) begin
              r_error <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_tvalid <= 1'b1;
              r_state  <= S_PUSH;
            end
          end
        end
        S_PUSH: begin
          if (out_tready) begin
            r_tvalid <= 1'b0;
            r_cnt    <= r_cnt - c_CNT_ONE;
            if (r_cnt != c_CNT_ONE) begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD_ADDR;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign out_tdata     = r_tdata;
  assign out_tvalid    = r_tvalid;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_fib_lfsr_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_fib_lfsr_cfg_seq
// Scoreboarded bench for fib_lfsr_cfg_seq with a reactive AXI4-Lite slave model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fib_lfsr_cfg_seq;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        start = 1'b0;
  logic [31:0] seed = '0;
  logic [31:0] ctrl_word = '0;
  logic [15:0] num_reads = '0;
  logic        busy, done, error;
  logic [31:0] out_tdata;
  logic        out_tvalid;
  logic        out_tready = 1'b1;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
  logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
  logic [31:0] m_axi_rdata = '0;

  fib_lfsr_cfg_seq dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .seed(seed), .ctrl_word(ctrl_word),
    .num_reads(num_reads), .busy(busy), .done(done), .error(error),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 ACLK = ~ACLK;

  // Successive states of the 16-bit Fibonacci LFSR starting from 0xACE1
  logic [31:0] rd_tab [4] = '{32'h0000_5670, 32'h0000_AB38, 32'h0000_559C, 32'h0000_2ACE};

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t         exp_wr [$];
  logic [31:0] exp_data [$];

  int n_checks = 0;
  int n_err    = 0;

  int aw_delay = 0, w_delay = 0, b_err_idx = -1, stall_cfg = 0;
  int aw_wait, w_wait, aw_hi, w_hi, aw_hi_first, w_hi_first;
  int wr_idx, rd_idx, ar_cnt, stall_left;
  bit aw_got, w_got, b_pend, ar_got, r_pend;
  logic [31:0] cap_awaddr, cap_wdata;
  int done_cnt, tv_cnt, beat_cnt, stall_seen;
  logic prev_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // AXI4-Lite slave and stream sink; handshakes are decided here and land on the next posedge
  always @(negedge ACLK) begin
    wr_t e;
    if (ARESET) begin
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
      aw_got = 0; w_got = 0; b_pend = 0; ar_got = 0; r_pend = 0;
      aw_wait = 0; w_wait = 0; aw_hi = 0; w_hi = 0;
    end else begin
      if (start && !busy) begin
        wr_idx = 0; rd_idx = 0; ar_cnt = 0; stall_left = stall_cfg;
        aw_hi_first = 0; w_hi_first = 0;
      end
      if (m_axi_bready) chk("bready_after_aw_w", 32'(aw_got && w_got), 32'd1);
      if (b_pend) begin
        m_axi_bvalid = 1'b0; b_pend = 0; aw_got = 0; w_got = 0;
        aw_wait = 0; w_wait = 0; aw_hi = 0; w_hi = 0; wr_idx++;
      end else if (!m_axi_bvalid && aw_got && w_got) begin
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = (wr_idx == b_err_idx) ? 2'b10 : 2'b00;
        if (wr_idx == 0) begin aw_hi_first = aw_hi; w_hi_first = w_hi; end
        if (exp_wr.size() == 0) chk("wr_unexpected", 32'd1, 32'(exp_wr.size()));
        else begin
          e = exp_wr.pop_front();
          chk("wr_addr", cap_awaddr, e.addr);
          chk("wr_data", cap_wdata, e.data);
        end
      end
      b_pend = m_axi_bvalid && m_axi_bready;
      if (m_axi_awvalid && !aw_got) begin
        aw_hi++; aw_wait++;
        m_axi_awready = (aw_wait >= aw_delay);
        if (m_axi_awready) begin aw_got = 1; cap_awaddr = m_axi_awaddr; end
      end else m_axi_awready = 1'b0;
      if (m_axi_wvalid && !w_got) begin
        w_hi++; w_wait++;
        m_axi_wready = (w_wait >= w_delay);
        if (m_axi_wready) begin
          w_got = 1; cap_wdata = m_axi_wdata;
          chk("wstrb", 32'(m_axi_wstrb), 32'hF);
        end
      end else m_axi_wready = 1'b0;
      if (r_pend) begin m_axi_rvalid = 1'b0; r_pend = 0; end
      if (!m_axi_rvalid && ar_got) begin
        m_axi_rvalid = 1'b1; m_axi_rresp = 2'b00;
        m_axi_rdata = rd_tab[rd_idx & 3]; rd_idx++; ar_got = 0;
      end
      r_pend = m_axi_rvalid && m_axi_rready;
      if (m_axi_arvalid && !ar_got && !m_axi_rvalid) begin
        m_axi_arready = 1'b1; ar_got = 1; ar_cnt++;
        chk("ar_addr", m_axi_araddr, 32'h0000_000C);
      end else m_axi_arready = 1'b0;
      if (out_tvalid && stall_left > 0) begin out_tready = 1'b0; stall_left--; end
      else out_tready = 1'b1;
    end
  end

  // Stream monitor: pops the scoreboard on every accepted beat
  always @(negedge ACLK) begin
    #1;
    if (!ARESET) begin
      if (start && !busy) begin done_cnt = 0; tv_cnt = 0; beat_cnt = 0; stall_seen = 0; end
      if (done) begin done_cnt++; chk("done_single_cycle", 32'(prev_done), 32'd0); end
      prev_done = done;
      if (out_tvalid) tv_cnt++;
      if (out_tvalid && out_tready) begin
        beat_cnt++;
        if (exp_data.size() == 0) chk("beat_unexpected", out_tdata, 32'hDEAD_BEEF);
        else chk("beat_data", out_tdata, exp_data.pop_front());
      end else if (out_tvalid) begin
        stall_seen++;
        if (exp_data.size() > 0) chk("stall_tdata_stable", out_tdata, exp_data[0]);
        chk("stall_no_ar", 32'(m_axi_arvalid), 32'd0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic kick(input logic [31:0] s, input logic [31:0] c, input logic [15:0] n,
                      input bit no_reads);
    exp_wr.push_back({32'h0000_0000, s});
    exp_wr.push_back({32'h0000_0004, c});
    if (!no_reads)
      for (int i = 0; i < int'(n) && i < 4; i++) exp_data.push_back(rd_tab[i]);
    cyc(1);
    seed = s; ctrl_word = c; num_reads = n; start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int k = 0;
    while (!done && k < lim) begin @(negedge ACLK); #2; k++; end
    chk("done_seen", 32'(done), 32'd1);
    cyc(3);
  endtask

  task automatic check_end(input logic exp_err, input int exp_ar, input int exp_beats);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("error_flag", 32'(error), 32'(exp_err));
    chk("ar_count", 32'(ar_cnt), 32'(exp_ar));
    chk("beat_count", 32'(beat_cnt), 32'(exp_beats));
    chk("stream_drained", 32'(exp_data.size()), 32'd0);
    chk("writes_drained", 32'(exp_wr.size()), 32'd0);
    chk("busy_low", 32'(busy), 32'd0);
  endtask

  initial begin
    int k;
    cyc(3);
    chk("rst_flags", {23'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                      m_axi_rready, out_tvalid, busy, done, error}, 32'd0);
    chk("rst_tdata", out_tdata, 32'd0);
    chk("rst_awaddr", m_axi_awaddr, 32'd0);
    chk("rst_wdata", m_axi_wdata, 32'd0);
    chk("rst_araddr", m_axi_araddr, 32'd0);
    ARESET = 1'b0;
    cyc(2);

    // Nominal four-read sequence
    kick(32'h0000_ACE1, 32'h1, 16'd4, 1'b0);
    wait_done(300);
    check_end(1'b0, 4, 4);

    // Zero reads: only the two writes
    kick(32'h0000_ACE1, 32'h1, 16'd0, 1'b0);
    wait_done(300);
    check_end(1'b0, 0, 0);
    chk("n0_tvalid_never", 32'(tv_cnt), 32'd0);

    // AW accepted late, W immediately
    aw_delay = 3;
    kick(32'h0000_1234, 32'h3, 16'd1, 1'b0);
    wait_done(300);
    chk("aw_valid_cycles", 32'(aw_hi_first), 32'd3);
    chk("w_valid_cycles", 32'(w_hi_first), 32'd1);
    check_end(1'b0, 1, 1);
    aw_delay = 0;

    // Stream back-pressure on the first beat
    stall_cfg = 5;
    kick(32'h0000_BEEF, 32'h1, 16'd2, 1'b0);
    wait_done(300);
    chk("stall_cycles", 32'(stall_seen), 32'd5);
    check_end(1'b0, 2, 2);
    stall_cfg = 0;

    // SLVERR on control write, then a clean run clears error
    b_err_idx = 1;
    kick(32'h0000_ACE1, 32'h1, 16'd3, 1'b1);
    wait_done(300);
    check_end(1'b1, 0, 0);
    b_err_idx = -1;
    kick(32'h0000_ACE1, 32'h1, 16'd1, 1'b0);
    chk("error_cleared_on_start", 32'(error), 32'd0);
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_done(300);
    check_end(1'b0, 1, 1);

    // Reset while waiting for read data
    kick(32'h0000_ACE1, 32'h1, 16'd3, 1'b0);
    k = 0;
    while (!m_axi_rready && k < 100) begin @(negedge ACLK); #2; k++; end
    chk("reached_rd_data", 32'(m_axi_rready), 32'd1);
    ARESET = 1'b1;
    #1;
    chk("midrst_flags", {23'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                         m_axi_rready, out_tvalid, busy, done, error}, 32'd0);
    chk("midrst_araddr", m_axi_araddr, 32'd0);
    exp_data.delete();
    exp_wr.delete();
    cyc(2);
    ARESET = 1'b0;
    cyc(2);
    kick(32'h0000_ACE1, 32'h1, 16'd4, 1'b0);
    wait_done(300);
    check_end(1'b0, 4, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_err);
    $fatal(1);
  end

endmodule
`default_nettype wire
